grad_update_sequencer: RTL and testbench



---
 rtl/grad_update_sequencer.sv | 179 +++++++++++++++++
 tb/tb_grad_update_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grad_update_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : grad_update_sequencer
//  Function : stages 4-channel gradient words, queues committed tuples and
//             releases one tuple per programmable interval to gpa_fhdo_iface.
//  Revision : 1.0
// ============================================================================
module grad_update_sequencer #(
    parameter int DEPTH      = 16,
    parameter int INTERVAL_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [23:0]             wr_data_i,
    input  logic [1:0]              wr_ch_i,
    input  logic                    wr_en_i,
    input  logic                    commit_i,
    input  logic [INTERVAL_W-1:0]   interval_i,
    input  logic                    enable_i,
    input  logic                    clr_flags_i,
    input  logic                    busy_i,
    output logic [23:0]             datax_o,
    output logic [23:0]             datay_o,
    output logic [23:0]             dataz_o,
    output logic [23:0]             dataz2_o,
    output logic                    valid_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    overrun_o,
    output logic                    underrun_o,
    output logic                    late_o
);
    localparam int                c_ADDR_W = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL   = (c_ADDR_W+1)'(DEPTH);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_WAIT = 2'd2;

    logic [23:0]           r_stage [4];
    logic [95:0]           r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_wptr, r_rptr;
    logic [c_ADDR_W:0]     r_count;
    logic [1:0]            r_state, w_state_nxt;
    logic [INTERVAL_W-1:0] r_cnt;
    logic [95:0]           r_data;
    logic                  r_valid, r_over, r_under, r_late;

    logic [23:0] w_tup [4];
    logic [95:0] w_tuple;
    logic        w_tick, w_hold, w_empty, w_issue, w_load;
    logic        w_push_ok, w_over_set, w_under_set, w_late_set;

    // A word written in the commit cycle is bypassed into the tuple.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_tup[i] = (wr_en_i && (wr_ch_i == 2'(i))) ? wr_data_i : r_stage[i];
        end
    end
    assign w_tuple = {w_tup[0], w_tup[1], w_tup[2], w_tup[3]};

    assign w_tick  = (r_cnt == '0);
    assign w_empty = (r_count == '0);
    // Blocking issue in the strobe cycle keeps valid_o off on back-to-back cycles.
    assign w_hold  = busy_i | r_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        w_under_set = 1'b0;
        w_late_set  = 1'b0;
        if (!enable_i) begin
            w_state_nxt = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    w_state_nxt = c_S_RUN;
                    w_load      = 1'b1;
                end
                c_S_RUN: begin
                    if (w_tick) begin
                        if (w_empty)     w_under_set = 1'b1;
                        else if (w_hold) w_state_nxt = c_S_WAIT;
                        else             w_issue     = 1'b1;
                    end
                end
                c_S_WAIT: begin
                    if (w_empty) begin
                        w_state_nxt = c_S_RUN;
                    end else if (!w_hold) begin
                        w_issue     = 1'b1;
                        w_state_nxt = c_S_RUN;
                    end else if (w_tick) begin
                        w_late_set  = 1'b1;
                    end
                end
                default: w_state_nxt = c_S_IDLE;
            endcase
        end
    end

    assign w_push_ok  = commit_i && ((r_count != c_FULL) || w_issue);
    assign w_over_set = commit_i && !w_push_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // The counter free-runs in WAIT as well so the tick schedule never slips.
            if (w_load) begin
                r_cnt <= interval_i;
            end else if (enable_i && (r_state != c_S_IDLE)) begin
                r_cnt <= w_tick ? interval_i : (r_cnt - INTERVAL_W'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) r_stage[i] <= '0;
        end else if (wr_en_i) begin
            r_stage[wr_ch_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= w_tuple;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + c_ADDR_W'(1);
            if (w_issue)   r_rptr <= r_rptr + c_ADDR_W'(1);
            case ({w_push_ok, w_issue})
                2'b10:   r_count <= r_count + (c_ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_over  <= 1'b0;
            r_under <= 1'b0;
            r_late  <= 1'b0;
        end else begin
            if (w_issue) r_data <= r_mem[r_rptr];
            r_valid <= w_issue;
            r_over  <= w_over_set  | (r_over  & ~clr_flags_i);
            r_under <= w_under_set | (r_under & ~clr_flags_i);
            r_late  <= w_late_set  | (r_late  & ~clr_flags_i);
        end
    end

    assign datax_o    = r_data[95:72];
    assign datay_o    = r_data[71:48];
    assign dataz_o    = r_data[47:24];
    assign dataz2_o   = r_data[23:0];
    assign valid_o    = r_valid;
    assign count_o    = r_count;
    assign full_o     = (r_count == c_FULL);
    assign empty_o    = w_empty;
    assign overrun_o  = r_over;
    assign underrun_o = r_under;
    assign late_o     = r_late;

endmodule
`default_nettype wire

// File: tb/tb_grad_update_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grad_update_sequencer
//  Function : directed/randomised bench for grad_update_sequencer with a
//             queue-based tuple model and cycle-number issue expectations.
//  Revision : 1.0
// ============================================================================
module tb_grad_update_sequencer;
    localparam int DEPTH      = 16;
    localparam int INTERVAL_W = 16;

    logic                  clk, rstn;
    logic [23:0]           wr_data_i;
    logic [1:0]            wr_ch_i;
    logic                  wr_en_i, commit_i, enable_i, clr_flags_i, busy_i;
    logic [INTERVAL_W-1:0] interval_i;
    logic [23:0]           datax_o, datay_o, dataz_o, dataz2_o;
    logic                  valid_o, full_o, empty_o, overrun_o, underrun_o, late_o;
    logic [4:0]            count_o;

    grad_update_sequencer #(.DEPTH(DEPTH), .INTERVAL_W(INTERVAL_W)) dut (
        .clk(clk), .rstn(rstn), .wr_data_i(wr_data_i), .wr_ch_i(wr_ch_i),
        .wr_en_i(wr_en_i), .commit_i(commit_i), .interval_i(interval_i),
        .enable_i(enable_i), .clr_flags_i(clr_flags_i), .busy_i(busy_i),
        .datax_o(datax_o), .datay_o(datay_o), .dataz_o(dataz_o), .dataz2_o(dataz2_o),
        .valid_o(valid_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
        .overrun_o(overrun_o), .underrun_o(underrun_o), .late_o(late_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert, n_fail;
    logic [23:0] st [4];
    logic [95:0] q [$];
    int          vexp [$];
    bit          exp_over;

    task automatic check_tup(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] out_tup();
        return {datax_o, datay_o, dataz_o, dataz2_o};
    endfunction

    function automatic bit in_vexp(input int c);
        foreach (vexp[i]) if (vexp[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Tuple model: accepted if room, or if a pop lands in the same cycle.
    task automatic model_push(input bit pop_same);
        if (q.size() < DEPTH || pop_same) q.push_back({st[0], st[1], st[2], st[3]});
        else exp_over = 1'b1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [23:0] v);
        wr_ch_i = ch; wr_data_i = v; wr_en_i = 1'b1;
        step();
        wr_en_i = 1'b0;
        st[ch] = v;
    endtask

    task automatic commit_idle(input bit byp, input logic [1:0] ch, input logic [23:0] v);
        commit_i = 1'b1; wr_en_i = byp; wr_ch_i = ch; wr_data_i = v;
        if (byp) st[ch] = v;
        step();
        commit_i = 1'b0; wr_en_i = 1'b0;
        model_push(1'b0);
    endtask

    task automatic rand_tuple();
        for (int ch = 0; ch < 4; ch++) wr(2'(ch), 24'($urandom()));
        commit_idle(1'b0, 2'd0, 24'd0);
    endtask

    // Runs ncyc cycles from the enable cycle; valid_o must rise exactly on vexp cycles.
    task automatic run_window(input int ncyc, input int b_lo, input int b_hi,
                              input int commit_c, input string tag);
        int bad, issues;
        bad = 0; issues = 0;
        for (int c = 0; c < ncyc; c++) begin
            bit          pop_next;
            logic [23:0] v;
            busy_i   = (c >= b_lo) && (c <= b_hi);
            pop_next = in_vexp(c + 1);
            if (c == commit_c) begin
                v = 24'($urandom());
                commit_i = 1'b1; wr_en_i = 1'b1; wr_ch_i = 2'd0; wr_data_i = v;
                st[0] = v;
                model_push(pop_next);
            end
            step();
            commit_i = 1'b0; wr_en_i = 1'b0;
            if (valid_o !== pop_next) bad++;
            if (valid_o === 1'b1) begin
                issues++;
                if (q.size() > 0) check_tup({tag, " data"}, out_tup(), q.pop_front());
                else bad++;
            end
        end
        busy_i = 1'b0;
        check_int({tag, " valid timing errors"}, bad, 0);
        check_int({tag, " issue count"}, issues, vexp.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        n_assert = 0; n_fail = 0; exp_over = 1'b0;
        for (int i = 0; i < 4; i++) st[i] = '0;
        rstn = 1'b1; wr_data_i = '0; wr_ch_i = '0; wr_en_i = 0; commit_i = 0;
        interval_i = '0; enable_i = 0; clr_flags_i = 0; busy_i = 0;
        #3 rstn = 1'b0;
        #10;
        check_tup("reset data", out_tup(), 96'd0);
        check_bit("reset valid", valid_o, 1'b0);
        check_int("reset count", int'(count_o), 0);
        check_bit("reset empty", empty_o, 1'b1);
        check_bit("reset full", full_o, 1'b0);
        check_int("reset flags", int'({overrun_o, underrun_o, late_o}), 0);
        @(negedge clk) rstn = 1'b1;
        step();

        // Basic issue at 2+I and period I+1, then underrun at the empty tick.
        wr(0, 24'd1); wr(1, 24'd2); wr(2, 24'd3); wr(3, 24'd4); commit_idle(0, 0, 0);
        wr(0, 24'd5); wr(1, 24'd6); wr(2, 24'd7); wr(3, 24'd8); commit_idle(0, 0, 0);
        check_int("basic count before run", int'(count_o), 2);
        interval_i = 16'd199; enable_i = 1'b1;
        vexp = '{201, 401};
        run_window(600, -1, -1, -1, "basic");
        check_bit("basic underrun before tick", underrun_o, 1'b0);
        step();
        check_bit("basic underrun at tick 600", underrun_o, 1'b1);
        check_int("basic count drained", int'(count_o), 0);
        check_tup("basic data hold", out_tup(), {24'd5, 24'd6, 24'd7, 24'd8});
        enable_i = 1'b0; step();
        clr_flags_i = 1'b1; step(); clr_flags_i = 1'b0;
        check_bit("clear underrun", underrun_o, 1'b0);

        // Partial update with same-cycle write+commit bypass.
        wr(0, 24'd1); wr(1, 24'd2); wr(2, 24'd3); wr(3, 24'd4); commit_idle(0, 0, 0);
        commit_idle(1, 2'd0, 24'($urandom()));
        interval_i = 16'd3; enable_i = 1'b1;
        vexp = '{5, 9};
        run_window(10, -1, -1, -1, "bypass");
        enable_i = 1'b0; step();

        // Busy holdoff around the tick at cycle 10, then a long busy giving late.
        rand_tuple(); rand_tuple();
        interval_i = 16'd9; enable_i = 1'b1;
        vexp = '{14, 21};
        run_window(22, 8, 12, -1, "busy5");
        check_bit("busy5 late", late_o, 1'b0);
        enable_i = 1'b0; step();
        rand_tuple(); rand_tuple();
        enable_i = 1'b1;
        vexp = '{34, 41};
        run_window(42, 8, 32, -1, "busy25");
        check_bit("busy25 late", late_o, 1'b1);
        enable_i = 1'b0; step();
        clr_flags_i = 1'b1; step(); clr_flags_i = 1'b0;
        check_int("flags cleared", int'({overrun_o, underrun_o, late_o}), 0);

        // Fill beyond DEPTH while idle, then push into a full FIFO on a pop.
        for (int k = 0; k < DEPTH + 1; k++) commit_idle(1, 2'($urandom_range(3)), 24'($urandom()));
        check_int("full count", int'(count_o), DEPTH);
        check_bit("full flag", full_o, 1'b1);
        check_bit("full empty flag", empty_o, 1'b0);
        check_bit("full overrun", overrun_o, exp_over);
        clr_flags_i = 1'b1; step(); clr_flags_i = 1'b0;
        check_bit("overrun cleared", overrun_o, 1'b0);
        interval_i = 16'd2; enable_i = 1'b1;
        vexp.delete();
        for (int k = 0; k < DEPTH + 1; k++) vexp.push_back(4 + 3 * k);
        run_window(52, -1, -1, 3, "full drain");
        check_bit("push on pop no overrun", overrun_o, 1'b0);
        check_bit("drained empty", empty_o, 1'b1);
        enable_i = 1'b0; step();

        // Clear alone clears; clear coincident with a new underrun loses.
        interval_i = 16'd1; enable_i = 1'b1;
        step(); step(); step();
        check_bit("underrun first tick", underrun_o, 1'b1);
        clr_flags_i = 1'b1; step();
        check_bit("underrun cleared", underrun_o, 1'b0);
        step(); clr_flags_i = 1'b0;
        check_bit("set beats clear", underrun_o, 1'b1);
        enable_i = 1'b0; step();

        // Disable while waiting on busy keeps the head tuple.
        rand_tuple();
        interval_i = 16'd4; enable_i = 1'b1; busy_i = 1'b1;
        nv = 0;
        for (int k = 0; k < 7; k++) begin step(); if (valid_o) nv++; end
        enable_i = 1'b0; busy_i = 1'b0;
        for (int k = 0; k < 6; k++) begin step(); if (valid_o) nv++; end
        check_int("disable in wait valids", nv, 0);
        check_int("disable in wait count", int'(count_o), 1);
        enable_i = 1'b1;
        vexp = '{6};
        run_window(6, -1, -1, -1, "reenable");
        enable_i = 1'b0; step();

        // Asynchronous reset with five queued tuples and an issue pending on busy.
        for (int k = 0; k < 5; k++) rand_tuple();
        interval_i = 16'd3; enable_i = 1'b1; busy_i = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check_int("pre-reset count", int'(count_o), 5);
        check_bit("pre-reset underrun", underrun_o, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check_tup("mid reset data", out_tup(), 96'd0);
        check_bit("mid reset valid", valid_o, 1'b0);
        check_int("mid reset count", int'(count_o), 0);
        check_bit("mid reset empty", empty_o, 1'b1);
        check_int("mid reset flags", int'({overrun_o, underrun_o, late_o}), 0);
        q.delete();
        for (int i = 0; i < 4; i++) st[i] = '0;
        busy_i = 1'b0;
        @(negedge clk) rstn = 1'b1;
        nv = 0;
        for (int k = 0; k < 12; k++) begin step(); if (valid_o) nv++; end
        check_int("post reset valids", nv, 0);
        check_int("post reset count", int'(count_o), 0);
        enable_i = 1'b0; step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
